// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU among N_REQ requesters. A round-robin grant
//   picks one request in IDLE and latches its operands, opcode and ID. The
//   registered operands drive the ALU during EXEC, the result is captured at
//   the end of EXEC, and RESP presents it on a valid/ready response port.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/A/B/sel      : per-requester request, packed slice i = requester i
//   req_ready              : one-hot accept, IDLE only
//   alu_A/alu_B/alu_sel    : to the external ALU (always the operand registers)
//   alu_out/alu_carry      : from the external ALU
//   rsp_valid/rsp_ready    : response handshake
//   rsp_id/data/carry      : owner ID and captured ALU result
//   busy                   : high whenever the FSM is not in IDLE
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_A,
    input  logic [N_REQ*WIDTH-1:0] req_B,
    input  logic [N_REQ*4-1:0]     req_sel,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       alu_A,
    output logic [WIDTH-1:0]       alu_B,
    output logic [3:0]             alu_sel,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic                   alu_carry,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_carry,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [3:0]        sel_q, sel_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              carry_q, carry_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]  gnt_a, gnt_b;
    logic [3:0]        gnt_sel;
    int                idx;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        gnt_sel   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
                gnt_a     = req_A[idx*WIDTH +: WIDTH];
                gnt_b     = req_B[idx*WIDTH +: WIDTH];
                gnt_sel   = req_sel[idx*4 +: 4];
            end
        end
    end

    // State register plus all datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            carry_q  <= carry_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath register updates.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        data_d   = data_q;
        carry_d  = carry_q;
        if (state_q == IDLE && gnt_found) begin
            id_d     = gnt_idx;
            a_d      = gnt_a;
            b_d      = gnt_b;
            sel_d    = gnt_sel;
            // Explicit wrap so non-power-of-two N_REQ stays in range.
            rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
        if (state_q == EXEC) begin
            data_d  = alu_out;
            carry_d = alu_carry;
        end
    end

    // Outputs. req_ready is masked by reset so nothing looks accepted
    // on an edge that will be discarded.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_found && !reset) req_ready[gnt_idx] = 1'b1;
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

    assign alu_A     = a_q;
    assign alu_B     = b_q;
    assign alu_sel   = sel_q;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_carry = carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_A, req_B;
    logic [N*4-1:0] req_sel;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   alu_A, alu_B, alu_out;
    logic [3:0]     alu_sel;
    logic           alu_carry;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_carry, busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {logic [1:0] id; logic [7:0] data; logic c;} exp_t;
    exp_t sb[$];

    // {a, b, sel} per operation, issued in round-robin order.
    logic [19:0] ops [12] = '{20'h0F_01_0, 20'h80_03_1, 20'h07_06_2, 20'h64_07_3,
                              20'h81_00_4, 20'h81_00_5, 20'h81_00_6, 20'h81_00_7,
                              20'hCC_AA_8, 20'hCC_AA_A, 20'h05_03_E, 20'h5A_5A_F};

    alu_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_A(req_A),
        .req_B(req_B), .req_sel(req_sel), .req_ready(req_ready),
        .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_carry(alu_carry), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model of the shared combinational ALU: {CarryOut, ALU_Out}.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
        logic [7:0] r;
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b};
        case (s)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a * b;
            4'h3: r = (b == 8'h00) ? 8'h00 : a / b;
            4'h4: r = a << 1;
            4'h5: r = a >> 1;
            4'h6: r = {a[6:0], a[7]};
            4'h7: r = {a[0], a[7:1]};
            4'h8: r = a & b;
            4'h9: r = a | b;
            4'hA: r = a ^ b;
            4'hB: r = ~(a | b);
            4'hC: r = ~(a & b);
            4'hD: r = ~(a ^ b);
            4'hE: r = (a > b) ? 8'd1 : 8'd0;
            default: r = (a == b) ? 8'd1 : 8'd0;
        endcase
        return {t[8], r};
    endfunction

    always_comb {alu_carry, alu_out} = alu_f(alu_A, alu_B, alu_sel);

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] s);
        req_A[i*8 +: 8]   = a;
        req_B[i*8 +: 8]   = b;
        req_sel[i*4 +: 4] = s;
    endtask

    task automatic push_exp(input int i);
        logic [8:0] r;
        r = alu_f(req_A[i*8 +: 8], req_B[i*8 +: 8], req_sel[i*4 +: 4]);
        sb.push_back({2'(i), r[7:0], r[8]});
    endtask

    // Empty scoreboard yields X so the following compare fails.
    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) e = 'x;
        else e = sb.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 8'(8'hA5 + i), 8'(8'h3C + i), 4'(i));
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++;
            if ({req_ready, rsp_valid, busy} !== 6'b0) begin
                errors++; $display("FAIL reset_ctl: got ready=%b v=%b busy=%b exp 0", req_ready, rsp_valid, busy);
            end
            checks++;
            if ({alu_A, alu_B, alu_sel} !== 20'h0) begin
                errors++; $display("FAIL reset_alu: got %h %h %h exp 0", alu_A, alu_B, alu_sel);
            end
        end
        checks++;
        if ({rsp_id, rsp_data, rsp_carry} !== 11'h0) begin
            errors++; $display("FAIL reset_rsp: got %0d %h %b exp 0", rsp_id, rsp_data, rsp_carry);
        end
        @(negedge clk); reset = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(2, 8'hF0, 8'h20, 4'b0000); req_valid = 4'b0100; #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_grant: got %b exp 0100", req_ready);
        end
        @(negedge clk); req_valid = '0; #1;
        checks++;
        if ({busy, rsp_valid, req_ready} !== 6'b100000) begin
            errors++; $display("FAIL single_exec: got busy=%b v=%b ready=%b exp 1 0 0000", busy, rsp_valid, req_ready);
        end
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== {1'b1, 2'd2, 8'h10, 1'b1}) begin
            errors++; $display("FAIL single_rsp: got v=%b id=%0d d=%h c=%b exp 1 2 10 1", rsp_valid, rsp_id, rsp_data, rsp_carry);
        end
        @(negedge clk); #1;
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL single_idle: got busy=%b v=%b exp 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int ngrant = 0, nresp = 0, last = 0, pend = -1, g;
        exp_t e;
        @(negedge clk); reset = 1'b1; req_valid = '0;
        @(negedge clk); reset = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, ops[i][19:12], ops[i][11:4], ops[i][3:0]);
        req_valid = '1;
        for (int cyc = 0; cyc < 200 && nresp < 12; cyc++) begin
            #1;
            if (rsp_valid) begin
                pop_exp(e);
                checks++;
                if ({rsp_id, rsp_data, rsp_carry} !== e) begin
                    errors++; $display("FAIL rr_rsp: got id=%0d d=%h c=%b exp id=%0d d=%h c=%b", rsp_id, rsp_data, rsp_carry, e.id, e.data, e.c);
                end
                nresp++;
            end
            if (req_ready != '0) begin
                g = ngrant % N;
                checks++;
                if (req_ready !== 4'(1 << g)) begin
                    errors++; $display("FAIL rr_grant: got %b exp %b", req_ready, 4'(1 << g));
                end
                if (ngrant > 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        errors++; $display("FAIL rr_interval: got %0d exp 3", cyc - last);
                    end
                end
                push_exp(g);
                pend = ngrant; last = cyc; ngrant++;
            end
            @(negedge clk);
            if (pend >= 0) begin
                g = pend % N;
                if (pend + N < 12) set_req(g, ops[pend+N][19:12], ops[pend+N][11:4], ops[pend+N][3:0]);
                else req_valid[g] = 1'b0;
                pend = -1;
            end
        end
        checks++;
        if (ngrant != 12 || nresp != 12) begin
            errors++; $display("FAIL rr_count: got grants=%0d rsps=%0d exp 12 12", ngrant, nresp);
        end
    endtask

    task automatic test_back_pressure();
        exp_t e;
        rsp_ready = 1'b0;
        set_req(1, 8'hC3, 8'h3D, 4'b0000); req_valid = 4'b0010; #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_grant: got %b exp 0010", req_ready);
        end
        push_exp(1);
        @(negedge clk); set_req(0, 8'h12, 8'h34, 4'b0001); req_valid = 4'b0001;
        @(negedge clk);
        e = sb[0];
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if ({rsp_valid, req_ready, rsp_id, rsp_data, rsp_carry} !== {1'b1, 4'b0000, e}) begin
                errors++; $display("FAIL bp_hold: got v=%b ready=%b id=%0d d=%h c=%b exp 1 0000 %0d %h %b", rsp_valid, req_ready, rsp_id, rsp_data, rsp_carry, e.id, e.data, e.c);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1; #1;
        pop_exp(e);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== {1'b1, e}) begin
            errors++; $display("FAIL bp_rsp: got v=%b id=%0d d=%h c=%b", rsp_valid, rsp_id, rsp_data, rsp_carry);
        end
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL bp_next_grant: got %b exp 0001", req_ready);
        end
        push_exp(0);
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        pop_exp(e);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== {1'b1, e}) begin
            errors++; $display("FAIL bp_rsp2: got v=%b id=%0d d=%h c=%b exp %0d %h %b", rsp_valid, rsp_id, rsp_data, rsp_carry, e.id, e.data, e.c);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        exp_t e;
        set_req(2, 8'h11, 8'h22, 4'b0000); req_valid = 4'b0100; rsp_ready = 1'b0;
        @(negedge clk); req_valid = '0; reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL rif_exec: got busy=%b v=%b exp 0 0", busy, rsp_valid);
        end
        req_valid = 4'b0100;
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL rif_in_resp: got v=%b exp 1", rsp_valid);
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({rsp_valid, busy, rsp_id, rsp_data, rsp_carry} !== 13'h0) begin
                errors++; $display("FAIL rif_dropped: got v=%b busy=%b id=%0d d=%h c=%b exp 0", rsp_valid, busy, rsp_id, rsp_data, rsp_carry);
            end
            @(negedge clk);
        end
        set_req(1, 8'h40, 8'h02, 4'b0010); set_req(3, 8'h09, 8'h04, 4'b1001);
        req_valid = 4'b1010; #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL rif_first: got %b exp 0010", req_ready);
        end
        push_exp(1);
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        pop_exp(e);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== {1'b1, e}) begin
            errors++; $display("FAIL rif_rsp: got v=%b id=%0d d=%h c=%b exp %0d %h %b", rsp_valid, rsp_id, rsp_data, rsp_carry, e.id, e.data, e.c);
        end
        @(negedge clk);
    endtask

    task automatic test_sparse_wrap();
        exp_t e;
        set_req(3, 8'hFF, 8'h01, 4'b0000); req_valid = 4'b1000; #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL wrap_g3: got %b exp 1000", req_ready);
        end
        push_exp(3);
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        pop_exp(e);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== {1'b1, e}) begin
            errors++; $display("FAIL wrap_rsp3: got v=%b id=%0d d=%h c=%b exp %0d %h %b", rsp_valid, rsp_id, rsp_data, rsp_carry, e.id, e.data, e.c);
        end
        @(negedge clk);
        set_req(0, 8'h7F, 8'h01, 4'b0001); set_req(2, 8'h33, 8'h0F, 4'b1100);
        req_valid = 4'b0101; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_g0: got %b exp 0001", req_ready);
        end
        push_exp(0);
        @(negedge clk); req_valid = 4'b0100;
        @(negedge clk); #1;
        pop_exp(e);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== {1'b1, e}) begin
            errors++; $display("FAIL wrap_rsp0: got v=%b id=%0d d=%h c=%b exp %0d %h %b", rsp_valid, rsp_id, rsp_data, rsp_carry, e.id, e.data, e.c);
        end
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL wrap_g2: got %b exp 0100", req_ready);
        end
        push_exp(2);
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        pop_exp(e);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== {1'b1, e}) begin
            errors++; $display("FAIL wrap_rsp2: got v=%b id=%0d d=%h c=%b exp %0d %h %b", rsp_valid, rsp_id, rsp_data, rsp_carry, e.id, e.data, e.c);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_reset_inflight();
        test_sparse_wrap();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d entries exp 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
